// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and the word-alignment width.
package apb_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    ERR    = 4'b1000
  } state_t;

  // Number of byte-address LSBs that must be zero for a word access.
  localparam int unsigned ALIGN_BITS = 2;

endpackage

// File: rtl/apb_master_bridge.sv
// CPU valid/ready request to APB master bridge with alignment check,
// stalled-transfer timeout and back-to-back transfer support.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned N_WIDTH = 32,
  parameter int unsigned N_ADDR  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               prstn,
  input  logic               cpu_req_valid,
  output logic               cpu_req_ready,
  input  logic               cpu_req_write,
  input  logic [N_ADDR-1:0]  cpu_req_addr,
  input  logic [N_WIDTH-1:0] cpu_req_wdata,
  output logic               cpu_rsp_valid,
  output logic [N_WIDTH-1:0] cpu_rsp_rdata,
  output logic               cpu_rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [N_ADDR-1:0]  paddr,
  output logic [N_WIDTH-1:0] pwdata,
  input  logic               pready,
  input  logic [N_WIDTH-1:0] prdata
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          accept, misaligned, done, abort;

  always_comb begin
    cpu_req_ready = (state == IDLE) || ((state == ACCESS) && pready);
    accept        = cpu_req_valid && cpu_req_ready;
    misaligned    = cpu_req_addr[ALIGN_BITS-1:0] != '0;
    done          = (state == ACCESS) && pready;
    abort         = (state == ACCESS) && !pready && (cnt == CNT_LAST);
    state_next    = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = misaligned ? ERR : SETUP;
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (accept)              state_next = misaligned ? ERR : SETUP;
        else if (done || abort)  state_next = IDLE;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state         <= IDLE;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      paddr         <= '0;
      pwdata        <= '0;
      cnt           <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_err   <= 1'b0;
      cpu_rsp_rdata <= '0;
    end else begin
      state   <= state_next;
      psel    <= (state_next == SETUP) || (state_next == ACCESS);
      penable <= (state_next == ACCESS);
      if (accept && !misaligned) begin
        paddr  <= cpu_req_addr;
        pwrite <= cpu_req_write;
        pwdata <= cpu_req_wdata;
      end
      if (state_next == SETUP)
        cnt <= '0;
      else if ((state == ACCESS) && !pready && (cnt != CNT_LAST))
        cnt <= cnt + CW'(1);
      // ERR responds one cycle late so it never collides with a completing transfer.
      cpu_rsp_valid <= done || abort || (state == ERR);
      cpu_rsp_err   <= abort || (state == ERR);
      cpu_rsp_rdata <= (done && !pwrite) ? prdata : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB SRAM slave model.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        prstn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready;
  logic [9:0]  paddr;
  logic [31:0] pwdata, prdata;

  int checks = 0;
  int errors = 0;

  // slave model controls
  logic        stall = 1'b0;
  int          waits = 0;
  int          acc_cycles = 0;
  logic [31:0] mem [256];

  apb_master_bridge #(.N_WIDTH(32), .N_ADDR(10), .TIMEOUT(4)) dut (
    .pclk(pclk), .prstn(prstn),
    .cpu_req_valid(req_valid), .cpu_req_ready(req_ready),
    .cpu_req_write(req_write), .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
    .cpu_rsp_valid(rsp_valid), .cpu_rsp_rdata(rsp_rdata), .cpu_rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  assign pready = !stall && (acc_cycles >= waits);
  assign prdata = mem[paddr[9:2]];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cycles <= acc_cycles + 1;
    else                            acc_cycles <= 0;
    if (psel && penable && pready && pwrite) mem[paddr[9:2]] <= pwdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [9:0] a,
                        input logic [31:0] wd, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rd, input logic exp_psel);
    int   lat;
    int   wait_n;
    logic seen_psel;
    @(negedge pclk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    #1;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(negedge pclk); #1; wait_n++;
    end
    check({tag, "_accept"}, req_ready, 1'b1);
    @(negedge pclk);
    req_valid = 1'b0;
    lat = 1;
    seen_psel = psel;
    while (!rsp_valid && lat < 40) begin
      @(negedge pclk); lat++; seen_psel |= psel;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_psel_seen"}, seen_psel, exp_psel);
    check({tag, "_psel_at_rsp"}, psel, 1'b0);
  endtask

  logic [9:0]  b_addr [3];
  logic        b_wr   [3];
  logic [31:0] b_wd   [3];
  logic [15:0] ready_vec, psel_vec, rsp_vec, err_vec;
  logic [31:0] rdata_log [16];

  task automatic burst(input int nreq, input int ncyc);
    int n;
    n = 0;
    ready_vec = '0; psel_vec = '0; rsp_vec = '0; err_vec = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge pclk);
      req_valid = (n < nreq);
      if (n < nreq) begin
        req_write = b_wr[n]; req_addr = b_addr[n]; req_wdata = b_wd[n];
      end
      #1;
      ready_vec[c] = req_ready; psel_vec[c] = psel;
      rsp_vec[c]   = rsp_valid; err_vec[c] = rsp_err;
      rdata_log[c] = rsp_rdata;
      if (req_valid && req_ready) n++;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "bench time limit");
  end

  initial begin
    int rsp_seen;
    // reset values
    repeat (2) @(negedge pclk);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 10'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    prstn = 1'b1;
    #1 check("idle_ready", req_ready, 1'b1);

    // single write with phase-by-phase bus checks
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h010; req_wdata = 32'hDEADBEEF;
    #1 check("wr_ready_T", req_ready, 1'b1);
    @(negedge pclk); req_valid = 1'b0;
    check("wr_setup_psel", psel, 1'b1);
    check("wr_setup_penable", penable, 1'b0);
    check("wr_setup_paddr", paddr, 10'h010);
    check("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    @(negedge pclk);
    check("wr_access_penable", penable, 1'b1);
    check("wr_access_pwrite", pwrite, 1'b1);
    check("wr_access_rsp", rsp_valid, 1'b0);
    @(negedge pclk);
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_err", rsp_err, 1'b0);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_rsp_psel", psel, 1'b0);
    @(negedge pclk);
    check("wr_rsp_pulse", rsp_valid, 1'b0);

    do_req("rd10", 1'b0, 10'h010, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1'b1);

    // back-to-back writes with valid held high
    b_addr[0] = 10'h000; b_wr[0] = 1'b1; b_wd[0] = 32'h11111111;
    b_addr[1] = 10'h004; b_wr[1] = 1'b1; b_wd[1] = 32'h22222222;
    b_addr[2] = 10'h008; b_wr[2] = 1'b1; b_wd[2] = 32'h33333333;
    burst(3, 10);
    check("b2b_ready", ready_vec[4:0], 5'b10101);
    check("b2b_psel", psel_vec[7:1], 7'b0111111);
    check("b2b_rsp", rsp_vec[9:0], 10'b0010101000);
    check("b2b_err", err_vec[9:0], 10'h0);

    do_req("misalign", 1'b0, 10'h012, 32'h0, 2, 1'b1, 32'h0, 1'b0);

    // misaligned request accepted at an ACCESS completion
    b_addr[0] = 10'h010; b_wr[0] = 1'b0; b_wd[0] = 32'h0;
    b_addr[1] = 10'h012; b_wr[1] = 1'b0; b_wd[1] = 32'h0;
    burst(2, 6);
    check("mis_cc_ready", ready_vec[2:0], 3'b101);
    check("mis_cc_rsp", rsp_vec[5:0], 6'b011000);
    check("mis_cc_err", err_vec[5:0], 6'b010000);
    check("mis_cc_rdata0", rdata_log[3], 32'hDEADBEEF);
    check("mis_cc_rdata1", rdata_log[4], 32'h0);
    check("mis_cc_nopsel", psel_vec[5:3], 3'b000);

    // timeout: ACCESS at T+2, abort at T+5, response at T+6
    stall = 1'b1;
    do_req("timeout", 1'b0, 10'h010, 32'h0, 6, 1'b1, 32'h0, 1'b1);
    stall = 1'b0;
    do_req("post_to_wr", 1'b1, 10'h020, 32'hCAFEF00D, 3, 1'b0, 32'h0, 1'b1);

    // reset asserted during ACCESS
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h030; req_wdata = 32'h55AA55AA;
    #1 check("rst_mid_accept", req_ready, 1'b1);
    @(negedge pclk); req_valid = 1'b0;
    @(negedge pclk);
    check("rst_mid_in_access", penable, 1'b1);
    #1 prstn = 1'b0;
    #1;
    check("rst_mid_psel", psel, 1'b0);
    check("rst_mid_penable", penable, 1'b0);
    check("rst_mid_paddr", paddr, 10'h0);
    check("rst_mid_pwdata", pwdata, 32'h0);
    check("rst_mid_pwrite", pwrite, 1'b0);
    rsp_seen = 0;
    repeat (2) begin
      @(negedge pclk); rsp_seen += int'(rsp_valid);
    end
    prstn = 1'b1;
    repeat (4) begin
      @(negedge pclk); rsp_seen += int'(rsp_valid);
    end
    check("rst_mid_no_rsp", rsp_seen, 0);
    do_req("post_rst_rd", 1'b0, 10'h010, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1'b1);

    // wait states below the abort threshold
    waits = 2;
    do_req("wait2_rd", 1'b0, 10'h008, 32'h0, 5, 1'b0, 32'h33333333, 1'b1);
    waits = 3;
    do_req("wait3_rd", 1'b0, 10'h004, 32'h0, 6, 1'b0, 32'h22222222, 1'b1);
    waits = 0;
    do_req("final_rd", 1'b0, 10'h020, 32'h0, 3, 1'b0, 32'hCAFEF00D, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
